apb_uart_fifo: RTL and testbench
================================

// Module: apb_uart_fifo
// PURPOSE
//  APB-attached UART with parametrised TX/RX FIFOs, runtime baud divisor, optional parity and 2-stop mode.
//  Successor to the single-buffer UART register block. Adds buffering, error flags and a maskable level IRQ.
//  Sits on the peripheral bus: CPU-side register slave, pin-side TxD/RxD.
// PARAMETERS
//  FIFO_DEPTH   16     entries per FIFO; power of 2, >=2
//  DIV_RESET    10416  reset value of BAUDDIV: clocks per bit (100 MHz / 9600)
//  RX_SYNC      2      RxD synchroniser flops
// PORTS
//  pClk       in   1   single clock; all logic on rising edge
//  pReset     in   1   synchronous, active-high reset
//  pSel       in   1   APB select
//  pEnable    in   1   APB access phase
//  pWrite     in   1   1=write, 0=read
//  pAddr      in   32  word index; only [2:0] decoded, other bits ignored
//  pWdata     in   32  write data
//  pReadData  out  32  read data
//  RxD        in   1   serial in, asynchronous, idle high
//  TxD        out  1   serial out, idle high
//  IRQ        out  1   |(IRQ_STAT & IRQ_EN)
// BEHAVIOUR
//  Reset: TxD=1, IRQ=0, pReadData=0, FIFOs empty, CTRL=0, BAUDDIV=DIV_RESET, IRQ_EN=0, sticky flags=0, FSMs IDLE.
//  APB: zero wait states. pReadData registered at the setup edge (pSel=1, pEnable=0); holds until next setup.
//   Side effects (write, RX pop, W1C) happen only at the access edge (pSel & pEnable).
//  Register map (index):
//   0 TXDATA  W: push pWdata[7:0]; if FIFO full, drop and set tx_drop. R: last byte written.
//   1 RXDATA  R: {23'b0, empty, byte}. Pops one entry at access edge. If empty: 0x100, no pop.
//   2 STATUS  R: [4:0] tx_level, [12:8] rx_level, [16] tx_full, [17] rx_empty, [18] tx_busy.
//   3 CTRL    RW [0] tx_en, [1] rx_en, [2] par_en, [3] par_odd, [4] stop2.
//   4 BAUDDIV RW [15:0]. Values <4 act as 4. A new value is used from the next bit boundary.
//   5 IRQ_EN  RW [5:0]
//   6 IRQ_STAT R: [0] rx_not_empty, [1] tx_empty (levels), [2] rx_overrun, [3] parity_err, [4] frame_err,
//     [5] tx_drop (sticky). W: write 1 to clear sticky bits. A set and a clear in the same cycle: set wins.
//   7 reserved: reads 0, writes ignored.
//  TX FSM: IDLE->START->DATA(8, LSB first)->[PARITY]->STOP(1 or 2)->IDLE; every bit lasts BAUDDIV clocks.
//   - Leaves IDLE when tx_en & !tx_empty; pops the FIFO on that edge. TxD is registered.
//   - Parity bit = ^data ^ par_odd.
//   - Clearing tx_en mid-frame lets the current frame finish; no new pop afterwards.
//   - Back-to-back frames: STOP->START with no idle gap if the FIFO is non-empty.
//  RX FSM: IDLE->START->DATA->[PARITY]->STOP->IDLE. Operates on the synchronised RxD.
//   - Falling edge in IDLE with rx_en=1 starts a frame. Wait BAUDDIV/2 and recheck.
//     If the line is high (glitch), return to IDLE. Otherwise sample every BAUDDIV clocks.
//   - STOP sampled 0: set frame_err; byte still pushed. Parity mismatch: set parity_err; byte pushed.
//   - Push on the STOP sample edge. If the FIFO is full: discard and set rx_overrun.
//   - Only the first stop bit is checked.
//  FIFO: simultaneous push and pop is legal when full or empty; level is unchanged, except when empty
//   (pop ignored, push succeeds). Pointers wrap modulo FIFO_DEPTH. Level width is clog2(FIFO_DEPTH)+1.
//  IRQ registered: asserts 1 clock after the cause.
//  Reset mid-frame: TxD=1 on the reset edge. Both FIFOs are flushed and any partial RX byte is lost.
// STRUCTURE
//  uart_pkg: register index constants, CTRL/IRQ bit positions, tx/rx state enums, DIV_MIN=4.
//  Sub-module uart_sync_fifo (WIDTH=8, DEPTH), instantiated twice, with full/empty/level outputs.
//  TX FSM, RX FSM, baud counters and APB decode stay in this module.
// TESTING (bench uses BAUDDIV=16, 10 ns clock)
//  1 Reset -> TxD=1, IRQ=0, STATUS=0x0002_0000, BAUDDIV reads 10416.
//  2 CTRL=0x01, write TXDATA 0x0A,0x55 -> TxD frames 0,0101_0000,1 then 0,1010_1010,1, each bit 16 clks.
//    No gap between frames. tx_empty IRQ bit rises after the 2nd stop bit.
//  3 CTRL=0x06 (rx_en, even parity), drive 0x14 with parity 0 -> RXDATA=0x014, rx_level then 0.
//    Repeat with parity 1 -> parity_err=1. Write IRQ_STAT 0x08 -> bit clears.
//  4 rx_en, send FIFO_DEPTH+1 bytes without reading -> rx_level=16, rx_overrun=1.
//    Reads return bytes 0..15 in order; 17th read returns 0x100.
//  5 tx_en=0, write 17 bytes -> tx_full=1, tx_drop=1. IRQ_EN=0x20 -> IRQ=1 next clock.
//  6 Assert pReset mid-TX data bit -> TxD=1 on the next edge, levels 0. A 3-clock low RxD glitch -> no push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the APB UART: register indices, control/IRQ bit
// positions, TX/RX state encodings and small parity/divisor helpers.
package uart_pkg;

   // Register word indices (pAddr[2:0])
   localparam logic [2:0] REG_TXDATA   = 3'd0;
   localparam logic [2:0] REG_RXDATA   = 3'd1;
   localparam logic [2:0] REG_STATUS   = 3'd2;
   localparam logic [2:0] REG_CTRL     = 3'd3;
   localparam logic [2:0] REG_BAUDDIV  = 3'd4;
   localparam logic [2:0] REG_IRQ_EN   = 3'd5;
   localparam logic [2:0] REG_IRQ_STAT = 3'd6;

   // CTRL bit positions
   localparam int CTRL_TX_EN   = 0;
   localparam int CTRL_RX_EN   = 1;
   localparam int CTRL_PAR_EN  = 2;
   localparam int CTRL_PAR_ODD = 3;
   localparam int CTRL_STOP2   = 4;

   // IRQ_STAT / IRQ_EN bit positions
   localparam int IRQ_OVERRUN = 2;
   localparam int IRQ_PARITY  = 3;
   localparam int IRQ_FRAME   = 4;
   localparam int IRQ_TX_DROP = 5;

   // TX FSM states
   localparam logic [2:0] TX_IDLE   = 3'd0;
   localparam logic [2:0] TX_START  = 3'd1;
   localparam logic [2:0] TX_DATA   = 3'd2;
   localparam logic [2:0] TX_PARITY = 3'd3;
   localparam logic [2:0] TX_STOP   = 3'd4;

   // RX FSM states
   localparam logic [2:0] RX_IDLE   = 3'd0;
   localparam logic [2:0] RX_START  = 3'd1;
   localparam logic [2:0] RX_DATA   = 3'd2;
   localparam logic [2:0] RX_PARITY = 3'd3;
   localparam logic [2:0] RX_STOP   = 3'd4;

   // Smallest usable clocks-per-bit; lower programmed values are clamped
   localparam logic [15:0] DIV_MIN = 16'd4;

   // Parity bit for a byte: even parity when odd=0
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   // Programmed divisor clamped to DIV_MIN
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div < DIV_MIN) ? DIV_MIN : div;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with full/empty/level; push while full succeeds only
// when a pop happens in the same cycle, pop while empty is ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level,
   output logic             overflow
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (level_r == {LW{1'b0}});
   assign full      = (level_r == LW'(DEPTH));
   assign do_pop_s  = pop & ~empty;
   assign do_push_s = push & (~full | do_pop_s);
   assign overflow  = push & ~do_push_s;
   assign rdata     = mem_r[rd_ptr_r];
   assign level     = level_r;

   // Storage write; contents need no reset since level gates visibility
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and level bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB-attached UART: register decode, TX/RX bit engines with runtime baud
// divisor, optional parity and two stop bits, sticky error flags and IRQ.
module apb_uart_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_RESET  = 10416,
   parameter int RX_SYNC    = 2
) (
   input  logic        pClk,
   input  logic        pReset,
   input  logic        pSel,
   input  logic        pEnable,
   input  logic        pWrite,
   input  logic [31:0] pAddr,
   input  logic [31:0] pWdata,
   output logic [31:0] pReadData,
   input  logic        RxD,
   output logic        TxD,
   output logic        IRQ
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   // APB decode
   logic       setup_s, wr_s, rd_acc_s;
   logic [2:0] idx_s;
   assign setup_s  = pSel & ~pEnable;
   assign wr_s     = pSel & pEnable & pWrite;
   assign rd_acc_s = pSel & pEnable & ~pWrite;
   assign idx_s    = pAddr[2:0];

   logic unused_bits_s;
   assign unused_bits_s = ^{pAddr[31:3], pWdata[31:16]};

   // Registers
   logic [4:0]  ctrl_r;
   logic [15:0] baud_r;
   logic [5:0]  irq_en_r;
   logic [7:0]  last_tx_r;
   logic        overrun_r, par_err_r, frame_err_r, tx_drop_r;
   logic        rx_pop_ok_r;
   logic [31:0] prdata_r;
   logic        irq_r;
   logic [31:0] rd_data_s, status_s;
   logic [5:0]  irq_stat_s, clr_s;

   // FIFO interfaces
   logic          tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_ovf_s;
   logic [7:0]    tx_rdata_s;
   logic [LW-1:0] tx_level_s;
   logic          rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, rx_ovf_s;
   logic [7:0]    rx_rdata_s;
   logic [LW-1:0] rx_level_s;

   // TX engine state
   logic [2:0]  tx_state_r, tx_bit_r;
   logic [15:0] tx_cnt_r;
   logic [7:0]  tx_shift_r;
   logic        tx_par_r, tx_par_en_r, tx_stop2_r, tx_second_r, txd_r;
   logic        tx_bit_end_s, tx_last_stop_s, tx_busy_s;

   // RX engine state
   logic [RX_SYNC-1:0] rx_sync_r;
   logic        rxd_s, rx_prev_r;
   logic [2:0]  rx_state_r, rx_bit_r;
   logic [15:0] rx_cnt_r;
   logic [7:0]  rx_shift_r;
   logic        rx_par_bit_r, rx_par_en_r, rx_par_odd_r, rx_bit_end_s;

   assign tx_push_s = wr_s & (idx_s == REG_TXDATA);
   assign rx_pop_s  = rd_acc_s & (idx_s == REG_RXDATA) & rx_pop_ok_r;

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(pClk), .rst(pReset), .push(tx_push_s), .pop(tx_pop_s),
      .wdata(pWdata[7:0]), .rdata(tx_rdata_s), .full(tx_full_s),
      .empty(tx_empty_s), .level(tx_level_s), .overflow(tx_ovf_s)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(pClk), .rst(pReset), .push(rx_push_s), .pop(rx_pop_s),
      .wdata(rx_shift_r), .rdata(rx_rdata_s), .full(rx_full_s),
      .empty(rx_empty_s), .level(rx_level_s), .overflow(rx_ovf_s)
   );

   // TX control: a new frame starts from IDLE or directly from the last stop bit
   assign tx_bit_end_s   = (tx_cnt_r == 16'd0);
   assign tx_busy_s      = (tx_state_r != TX_IDLE);
   assign tx_last_stop_s = (tx_state_r == TX_STOP) & tx_bit_end_s & (~tx_stop2_r | tx_second_r);
   assign tx_pop_s       = ctrl_r[CTRL_TX_EN] & ~tx_empty_s & ((tx_state_r == TX_IDLE) | tx_last_stop_s);

   // TX bit engine; divisor reloaded at every bit boundary
   always_ff @(posedge pClk) begin
      if (pReset) begin
         tx_state_r  <= TX_IDLE;
         tx_bit_r    <= 3'd0;
         tx_cnt_r    <= 16'd0;
         tx_shift_r  <= 8'd0;
         tx_par_r    <= 1'b0;
         tx_par_en_r <= 1'b0;
         tx_stop2_r  <= 1'b0;
         tx_second_r <= 1'b0;
         txd_r       <= 1'b1;
      end else if (tx_pop_s) begin
         tx_state_r  <= TX_START;
         txd_r       <= 1'b0;
         tx_cnt_r    <= eff_div(baud_r) - 16'd1;
         tx_shift_r  <= tx_rdata_s;
         tx_par_r    <= parity_bit(tx_rdata_s, ctrl_r[CTRL_PAR_ODD]);
         tx_par_en_r <= ctrl_r[CTRL_PAR_EN];
         tx_stop2_r  <= ctrl_r[CTRL_STOP2];
         tx_second_r <= 1'b0;
      end else if (tx_busy_s) begin
         if (!tx_bit_end_s) begin
            tx_cnt_r <= tx_cnt_r - 16'd1;
         end else begin
            tx_cnt_r <= eff_div(baud_r) - 16'd1;
            case (tx_state_r)
               TX_START: begin
                  tx_state_r <= TX_DATA;
                  tx_bit_r   <= 3'd0;
                  txd_r      <= tx_shift_r[0];
               end
               TX_DATA: begin
                  if (tx_bit_r == 3'd7) begin
                     tx_state_r  <= tx_par_en_r ? TX_PARITY : TX_STOP;
                     txd_r       <= tx_par_en_r ? tx_par_r : 1'b1;
                     tx_second_r <= 1'b0;
                  end else begin
                     tx_bit_r   <= tx_bit_r + 3'd1;
                     tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                     txd_r      <= tx_shift_r[1];
                  end
               end
               TX_PARITY: begin
                  tx_state_r  <= TX_STOP;
                  txd_r       <= 1'b1;
                  tx_second_r <= 1'b0;
               end
               TX_STOP: begin
                  txd_r <= 1'b1;
                  if (tx_stop2_r && !tx_second_r) tx_second_r <= 1'b1;
                  else                            tx_state_r  <= TX_IDLE;
               end
               default: begin
                  tx_state_r <= TX_IDLE;
                  txd_r      <= 1'b1;
               end
            endcase
         end
      end else begin
         txd_r <= 1'b1;
      end
   end

   // RxD synchroniser and edge-detect history, idle high
   always_ff @(posedge pClk) begin
      if (pReset) begin
         rx_sync_r <= {RX_SYNC{1'b1}};
         rx_prev_r <= 1'b1;
      end else begin
         rx_sync_r <= {rx_sync_r[RX_SYNC-2:0], RxD};
         rx_prev_r <= rxd_s;
      end
   end

   assign rxd_s        = rx_sync_r[RX_SYNC-1];
   assign rx_bit_end_s = (rx_cnt_r == 16'd0);
   assign rx_push_s    = (rx_state_r == RX_STOP) & rx_bit_end_s;

   // RX bit engine: half-bit start validation then mid-bit sampling
   always_ff @(posedge pClk) begin
      if (pReset) begin
         rx_state_r   <= RX_IDLE;
         rx_bit_r     <= 3'd0;
         rx_cnt_r     <= 16'd0;
         rx_shift_r   <= 8'd0;
         rx_par_bit_r <= 1'b0;
         rx_par_en_r  <= 1'b0;
         rx_par_odd_r <= 1'b0;
      end else if (rx_state_r == RX_IDLE) begin
         if (ctrl_r[CTRL_RX_EN] && rx_prev_r && !rxd_s) begin
            rx_state_r   <= RX_START;
            rx_cnt_r     <= (eff_div(baud_r) >> 1) - 16'd1;
            rx_par_en_r  <= ctrl_r[CTRL_PAR_EN];
            rx_par_odd_r <= ctrl_r[CTRL_PAR_ODD];
         end else begin
            rx_state_r <= RX_IDLE;
         end
      end else if (!rx_bit_end_s) begin
         rx_cnt_r <= rx_cnt_r - 16'd1;
      end else begin
         rx_cnt_r <= eff_div(baud_r) - 16'd1;
         case (rx_state_r)
            RX_START: begin
               rx_state_r <= rxd_s ? RX_IDLE : RX_DATA;
               rx_bit_r   <= 3'd0;
            end
            RX_DATA: begin
               rx_shift_r <= {rxd_s, rx_shift_r[7:1]};
               rx_bit_r   <= rx_bit_r + 3'd1;
               if (rx_bit_r == 3'd7) rx_state_r <= rx_par_en_r ? RX_PARITY : RX_STOP;
               else                  rx_state_r <= RX_DATA;
            end
            RX_PARITY: begin
               rx_par_bit_r <= rxd_s;
               rx_state_r   <= RX_STOP;
            end
            default: rx_state_r <= RX_IDLE;
         endcase
      end
   end

   assign clr_s      = (wr_s && idx_s == REG_IRQ_STAT) ? pWdata[5:0] : 6'd0;
   assign irq_stat_s = {tx_drop_r, frame_err_r, par_err_r, overrun_r,
                        tx_empty_s & ~tx_busy_s, ~rx_empty_s};

   // Control registers and sticky flags; a set beats a same-cycle clear
   always_ff @(posedge pClk) begin
      if (pReset) begin
         ctrl_r      <= 5'd0;
         baud_r      <= 16'(DIV_RESET);
         irq_en_r    <= 6'd0;
         last_tx_r   <= 8'd0;
         overrun_r   <= 1'b0;
         par_err_r   <= 1'b0;
         frame_err_r <= 1'b0;
         tx_drop_r   <= 1'b0;
         irq_r       <= 1'b0;
      end else begin
         if (wr_s) begin
            case (idx_s)
               REG_TXDATA:  last_tx_r <= pWdata[7:0];
               REG_CTRL:    ctrl_r    <= pWdata[4:0];
               REG_BAUDDIV: baud_r    <= pWdata[15:0];
               REG_IRQ_EN:  irq_en_r  <= pWdata[5:0];
               default:     ctrl_r    <= ctrl_r;
            endcase
         end
         overrun_r   <= rx_ovf_s | (overrun_r & ~clr_s[IRQ_OVERRUN]);
         par_err_r   <= (rx_push_s & rx_par_en_r & (rx_par_bit_r != parity_bit(rx_shift_r, rx_par_odd_r)))
                        | (par_err_r & ~clr_s[IRQ_PARITY]);
         frame_err_r <= (rx_push_s & ~rxd_s) | (frame_err_r & ~clr_s[IRQ_FRAME]);
         tx_drop_r   <= tx_ovf_s | (tx_drop_r & ~clr_s[IRQ_TX_DROP]);
         irq_r       <= |(irq_stat_s & irq_en_r);
      end
   end

   // STATUS word assembly
   always_comb begin
      status_s          = 32'd0;
      status_s[LW-1:0]  = tx_level_s;
      status_s[8 +: LW] = rx_level_s;
      status_s[16]      = tx_full_s;
      status_s[17]      = rx_empty_s;
      status_s[18]      = tx_busy_s;
   end

   // Read mux for the register addressed in the setup phase
   always_comb begin
      rd_data_s = 32'd0;
      case (idx_s)
         REG_TXDATA:   rd_data_s = {24'd0, last_tx_r};
         REG_RXDATA:   rd_data_s = rx_empty_s ? 32'h0000_0100 : {24'd0, rx_rdata_s};
         REG_STATUS:   rd_data_s = status_s;
         REG_CTRL:     rd_data_s = {27'd0, ctrl_r};
         REG_BAUDDIV:  rd_data_s = {16'd0, baud_r};
         REG_IRQ_EN:   rd_data_s = {26'd0, irq_en_r};
         REG_IRQ_STAT: rd_data_s = {26'd0, irq_stat_s};
         default:      rd_data_s = 32'd0;
      endcase
   end

   // Read data captured at the setup edge; remember whether an RX pop is owed
   always_ff @(posedge pClk) begin
      if (pReset) begin
         prdata_r    <= 32'd0;
         rx_pop_ok_r <= 1'b0;
      end else if (setup_s) begin
         prdata_r    <= rd_data_s;
         rx_pop_ok_r <= ~pWrite & (idx_s == REG_RXDATA) & ~rx_empty_s;
      end else begin
         prdata_r    <= prdata_r;
         rx_pop_ok_r <= rx_pop_ok_r;
      end
   end

   assign pReadData = prdata_r;
   assign TxD       = txd_r;
   assign IRQ       = irq_r;

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Scoreboard bench for apb_uart_fifo: stimulus pushes expected read data and
// expected TX frames into queues; monitors pop and compare as the DUT responds.
module tb_apb_uart_fifo;

   logic        pClk = 1'b0;
   logic        pReset = 1'b1;
   logic        pSel = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
   logic [31:0] pAddr = 32'd0, pWdata = 32'd0;
   logic [31:0] pReadData;
   logic        RxD = 1'b1;
   logic        TxD, IRQ;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   string       rd_name_q[$];
   logic [31:0] rd_exp_q[$];
   logic [7:0]  tx_exp_q[$];
   int          tx_gap_q[$];
   bit          tx_mon_en = 1'b0;

   always #5 pClk = ~pClk;

   apb_uart_fifo dut (
      .pClk(pClk), .pReset(pReset), .pSel(pSel), .pEnable(pEnable),
      .pWrite(pWrite), .pAddr(pAddr), .pWdata(pWdata), .pReadData(pReadData),
      .RxD(RxD), .TxD(TxD), .IRQ(IRQ)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      tot_cnt++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
      pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddr = a; pWdata = d;
      @(posedge pClk); #1 pEnable = 1'b1;
      @(posedge pClk); #1 pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
   endtask

   task automatic apb_rd(input logic [31:0] a, input string name, input logic [31:0] exp);
      rd_name_q.push_back(name);
      rd_exp_q.push_back(exp);
      pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddr = a;
      @(posedge pClk); #1 pEnable = 1'b1;
      @(posedge pClk); #1 pSel = 1'b0; pEnable = 1'b0;
   endtask

   task automatic rx_bit(input logic v);
      RxD = v;
      repeat (16) @(posedge pClk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b, input bit use_par, input logic par);
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(b[i]);
      if (use_par) rx_bit(par);
      rx_bit(1'b1);
   endtask

   // Read monitor: compare every access-phase read against the scoreboard
   always @(negedge pClk) begin : rd_mon
      string       n;
      logic [31:0] e;
      if (pSel && pEnable && !pWrite) begin
         if (rd_exp_q.size() == 0) begin
            fail_now("unexpected_read");
         end else begin
            n = rd_name_q.pop_front();
            e = rd_exp_q.pop_front();
            check(n, pReadData, e);
         end
      end
   end

   // TX monitor: decode frames (16 clocks/bit, no parity) and check gap
   initial begin : tx_mon
      int         gap;
      int         start_gap;
      int         exp_gap;
      logic [7:0] b;
      logic       stop_v;
      gap = 0;
      forever begin
         @(negedge pClk);
         gap++;
         if (tx_mon_en && TxD == 1'b0) begin
            start_gap = gap;
            repeat (7) @(negedge pClk);
            check("tx_start_bit", {31'd0, TxD}, 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (16) @(negedge pClk);
               b[i] = TxD;
            end
            repeat (16) @(negedge pClk);
            stop_v = TxD;
            if (tx_exp_q.size() == 0) begin
               fail_now("unexpected_tx_frame");
            end else begin
               exp_gap = tx_gap_q.pop_front();
               check("tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
               check("tx_stop_bit", {31'd0, stop_v}, 32'd1);
               if (exp_gap >= 0) check("tx_frame_gap", start_gap, exp_gap);
            end
            gap = 0;
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      repeat (3) @(posedge pClk);
      #1 pReset = 1'b0;

      // 1: reset state
      check("reset_txd", {31'd0, TxD}, 32'd1);
      check("reset_irq", {31'd0, IRQ}, 32'd0);
      check("reset_prdata", pReadData, 32'd0);
      apb_rd(32'd2, "reset_status", 32'h0002_0000);
      apb_rd(32'd4, "reset_bauddiv", 32'd10416);
      apb_rd(32'd3, "reset_ctrl", 32'd0);
      apb_rd(32'd5, "reset_irq_en", 32'd0);
      apb_rd(32'd6, "reset_irq_stat", 32'h0000_0002);
      apb_rd(32'h0000_0007, "reserved_reg", 32'd0);

      // 2: two back-to-back TX frames
      apb_wr(32'd4, 32'd16);
      apb_wr(32'd3, 32'h01);
      tx_mon_en = 1'b1;
      tx_exp_q.push_back(8'h0A); tx_gap_q.push_back(-1);
      tx_exp_q.push_back(8'h55); tx_gap_q.push_back(9);
      apb_wr(32'd0, 32'h0A);
      apb_wr(32'd0, 32'h55);
      repeat (200) @(posedge pClk);
      #1 apb_rd(32'd6, "irq_stat_mid_frame2", 32'h0000_0000);
      apb_rd(32'd0, "txdata_last", 32'h55);
      n = 0;
      while (tx_exp_q.size() != 0 && n < 1000) begin
         @(posedge pClk);
         n++;
      end
      #1;
      if (n >= 1000) fail_now("tx_frames_timeout");
      apb_rd(32'd6, "irq_stat_in_stop2", 32'h0000_0000);
      repeat (12) @(posedge pClk);
      #1 apb_rd(32'd6, "irq_stat_tx_done", 32'h0000_0002);
      tx_mon_en = 1'b0;

      // 3: RX with even parity, good then bad parity
      apb_wr(32'd3, 32'h06);
      send_rx(8'h14, 1'b1, 1'b0);
      apb_rd(32'd2, "status_rx_one", 32'h0000_0100);
      apb_rd(32'd1, "rxdata_good_par", 32'h0000_0014);
      apb_rd(32'd2, "status_rx_drained", 32'h0002_0000);
      send_rx(8'h14, 1'b1, 1'b1);
      apb_rd(32'd6, "irq_stat_par_err", 32'h0000_000B);
      apb_rd(32'd1, "rxdata_bad_par", 32'h0000_0014);
      apb_wr(32'd6, 32'h08);
      apb_rd(32'd6, "irq_stat_par_cleared", 32'h0000_0002);

      // 4: RX overrun with FIFO_DEPTH+1 bytes
      apb_wr(32'd3, 32'h02);
      for (int i = 0; i < 17; i++) send_rx(8'(i), 1'b0, 1'b0);
      apb_rd(32'd2, "status_rx_full", 32'h0000_1000);
      apb_rd(32'd6, "irq_stat_overrun", 32'h0000_0007);
      for (int i = 0; i < 16; i++) apb_rd(32'd1, "rx_fifo_order", 32'(i));
      apb_rd(32'd1, "rxdata_empty", 32'h0000_0100);
      apb_wr(32'd6, 32'h3F);
      apb_rd(32'd6, "irq_stat_all_cleared", 32'h0000_0002);

      // 5: TX FIFO overflow with transmitter disabled, tx_drop IRQ
      apb_wr(32'd3, 32'h00);
      for (int i = 0; i < 17; i++) apb_wr(32'd0, 32'h80 + 32'(i));
      apb_rd(32'd2, "status_tx_full", 32'h0003_0010);
      apb_rd(32'd6, "irq_stat_tx_drop", 32'h0000_0020);
      apb_rd(32'd0, "txdata_dropped_last", 32'h0000_0090);
      apb_wr(32'd5, 32'h20);
      @(negedge pClk);
      check("irq_same_clock", {31'd0, IRQ}, 32'd0);
      @(posedge pClk); #1;
      check("irq_next_clock", {31'd0, IRQ}, 32'd1);

      // 6: reset mid data bit, then RX glitch rejection
      apb_wr(32'd3, 32'h01);
      repeat (40) @(posedge pClk);
      #1 check("txd_data_bit_low", {31'd0, TxD}, 32'd0);
      pReset = 1'b1;
      @(posedge pClk); #1;
      check("txd_on_reset_edge", {31'd0, TxD}, 32'd1);
      pReset = 1'b0;
      check("irq_after_reset", {31'd0, IRQ}, 32'd0);
      apb_rd(32'd2, "status_after_reset", 32'h0002_0000);
      apb_rd(32'd4, "baud_after_reset", 32'd10416);
      apb_wr(32'd4, 32'd16);
      apb_wr(32'd3, 32'h02);
      RxD = 1'b0;
      repeat (3) @(posedge pClk);
      #1 RxD = 1'b1;
      repeat (40) @(posedge pClk);
      #1 apb_rd(32'd2, "status_after_glitch", 32'h0002_0000);
      send_rx(8'hA5, 1'b0, 1'b0);
      apb_rd(32'd1, "rxdata_after_glitch", 32'h0000_00A5);

      repeat (5) @(posedge pClk);
      if (rd_exp_q.size() != 0) fail_now("reads_outstanding");
      if (tx_exp_q.size() != 0) fail_now("tx_frames_outstanding");
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
